// File: rtl/hsid_pkg.sv
// Shared types and default widths for the HSID distance pipeline.
package hsid_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } hsid_sq_acc_state_t;

   localparam int HSID_DATA_WIDTH     = 16;
   localparam int HSID_BAND_CNT_WIDTH = 8;

endpackage

// File: rtl/hsid_sat_add.sv
// Combinational W-bit adder with carry-out as overflow flag.
// Saturates at all-ones when HSID_SQ_ACC_SAT_EN is defined, wraps otherwise.
module hsid_sat_add #(
   parameter int W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] full;

   assign full = {1'b0, a} + {1'b0, b};
   assign ovf  = full[W];

`ifdef HSID_SQ_ACC_SAT_EN
   assign sum = full[W] ? {W{1'b1}} : full[W-1:0];
`else
   assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/hsid_sq_acc.sv
// Per-pixel squared-difference accumulator with registered valid/ready result.
// HSID_SQ_ACC_SAT_EN selects saturating sum plus overflow flag; default wraps.
module hsid_sq_acc
   import hsid_pkg::*;
#(
   parameter int DATA_WIDTH     = HSID_DATA_WIDTH,
   parameter int ACC_WIDTH      = 40,
   parameter int BAND_CNT_WIDTH = HSID_BAND_CNT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      sq_valid_in,
   input  logic [2*DATA_WIDTH-1:0]   sq_data_in,
   input  logic                      sq_last_in,
   output logic                      sq_ready_out,
   output logic                      acc_valid_out,
   input  logic                      acc_ready_in,
   output logic [ACC_WIDTH-1:0]      acc_data_out,
   output logic [BAND_CNT_WIDTH-1:0] acc_band_cnt_out,
   output logic                      acc_ovf_out
);

   hsid_sq_acc_state_t        state;
   logic [ACC_WIDTH-1:0]      psum;
   logic [BAND_CNT_WIDTH-1:0] pcnt;
   logic [ACC_WIDTH-1:0]      add_a, add_b, add_sum;
   logic                      add_ovf;
   logic [BAND_CNT_WIDTH-1:0] nxt_cnt;
   logic                      accept;

   assign sq_ready_out = !acc_valid_out || acc_ready_in;
   assign accept       = sq_valid_in && sq_ready_out;

   // Outside ACC a sample opens a fresh pixel, so the adder sees zero.
   assign add_a   = (state == ACC) ? psum : '0;
   assign add_b   = ACC_WIDTH'(sq_data_in);
   assign nxt_cnt = (state != ACC) ? BAND_CNT_WIDTH'(1) :
                    (&pcnt)        ? pcnt : pcnt + BAND_CNT_WIDTH'(1);

   hsid_sat_add #(.W(ACC_WIDTH)) u_add (
      .a   (add_a),
      .b   (add_b),
      .sum (add_sum),
      .ovf (add_ovf)
   );

`ifdef HSID_SQ_ACC_SAT_EN
   logic povf, nxt_ovf;
   assign nxt_ovf = ((state == ACC) && povf) || add_ovf;
`else
   logic unused_add_ovf;
   assign unused_add_ovf = add_ovf;
   assign acc_ovf_out    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         psum             <= '0;
         pcnt             <= '0;
         acc_valid_out    <= 1'b0;
         acc_data_out     <= '0;
         acc_band_cnt_out <= '0;
`ifdef HSID_SQ_ACC_SAT_EN
         povf             <= 1'b0;
         acc_ovf_out      <= 1'b0;
`endif
      end else if (clear) begin
         state            <= IDLE;
         psum             <= '0;
         pcnt             <= '0;
         acc_valid_out    <= 1'b0;
         acc_data_out     <= '0;
         acc_band_cnt_out <= '0;
`ifdef HSID_SQ_ACC_SAT_EN
         povf             <= 1'b0;
         acc_ovf_out      <= 1'b0;
`endif
      end else if (accept) begin
         // An accept in HOLD implies acc_ready_in, so the old result is consumed here.
         if (sq_last_in) begin
            acc_data_out     <= add_sum;
            acc_band_cnt_out <= nxt_cnt;
            acc_valid_out    <= 1'b1;
            psum             <= '0;
            pcnt             <= '0;
            state            <= HOLD;
`ifdef HSID_SQ_ACC_SAT_EN
            acc_ovf_out      <= nxt_ovf;
            povf             <= 1'b0;
`endif
         end else begin
            psum          <= add_sum;
            pcnt          <= nxt_cnt;
            acc_valid_out <= 1'b0;
            state         <= ACC;
`ifdef HSID_SQ_ACC_SAT_EN
            povf          <= nxt_ovf;
`endif
         end
      end else if ((state == HOLD) && acc_ready_in) begin
         acc_valid_out <= 1'b0;
         state         <= IDLE;
      end
   end

endmodule
